// File: rtl/cam_init_pkg.sv
// Shared definitions for the camera bring-up sequencer.
// Holds the state encoding, default OV-sensor timing at 50 MHz, and the per-state pin decode.
package cam_init_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_PWDN  = 3'd1;
   localparam logic [2:0] ST_RST   = 3'd2;
   localparam logic [2:0] ST_WAIT  = 3'd3;
   localparam logic [2:0] ST_CFG   = 3'd4;
   localparam logic [2:0] ST_READY = 3'd5;
   localparam logic [2:0] ST_FAIL  = 3'd6;

   localparam int unsigned CNT_W_DEF           = 32;
   localparam int unsigned PWDN_CYCLES_DEF     = 1_000_000;
   localparam int unsigned RST_LOW_CYCLES_DEF  = 500_000;
   localparam int unsigned RST_WAIT_CYCLES_DEF = 1_000_000;
   localparam int unsigned TIMEOUT_CYCLES_DEF  = 50_000_000;
   localparam int unsigned MAX_RETRY_DEF       = 3;

   typedef struct packed {
      logic cam_pwdn;
      logic cam_rst_n;
      logic cfg_rst;
      logic busy;
      logic cam_ready;
      logic init_fail;
   } pins_t;

   // Unused encodings fall back to the safe powered-down pin pattern.
   function automatic pins_t state_pins(input logic [2:0] st);
      pins_t p;
      p.cam_pwdn  = 1'b1;
      p.cam_rst_n = 1'b0;
      p.cfg_rst   = 1'b1;
      p.busy      = 1'b0;
      p.cam_ready = 1'b0;
      p.init_fail = 1'b0;
      case (st)
         ST_PWDN: begin
            p.busy = 1'b1;
         end
         ST_RST: begin
            p.cam_pwdn = 1'b0;
            p.busy     = 1'b1;
         end
         ST_WAIT: begin
            p.cam_pwdn  = 1'b0;
            p.cam_rst_n = 1'b1;
            p.busy      = 1'b1;
         end
         ST_CFG: begin
            p.cam_pwdn  = 1'b0;
            p.cam_rst_n = 1'b1;
            p.cfg_rst   = 1'b0;
            p.busy      = 1'b1;
         end
         ST_READY: begin
            p.cam_pwdn  = 1'b0;
            p.cam_rst_n = 1'b1;
            p.cfg_rst   = 1'b0;
            p.cam_ready = 1'b1;
         end
         ST_FAIL: begin
            p.init_fail = 1'b1;
         end
         default: ;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/cam_init_timer.sv
// Loadable down-counter used to time each sequencer state.
// Saturates at zero; expired flags the terminal count.
module cam_init_timer
   import cam_init_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             expired,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (count_q != '0) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count   = count_q;
   assign expired = (count_q == '0);

endmodule

// File: rtl/cam_init_ctrl.sv
// Camera bring-up sequencer: power-down, hardware reset, settle, then I2C config
// with retry on error/timeout; reports ready or fail to the video pipeline.
module cam_init_ctrl
   import cam_init_pkg::*;
#(
   parameter int unsigned PWDN_CYCLES     = PWDN_CYCLES_DEF,
   parameter int unsigned RST_LOW_CYCLES  = RST_LOW_CYCLES_DEF,
   parameter int unsigned RST_WAIT_CYCLES = RST_WAIT_CYCLES_DEF,
   parameter int unsigned TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEF,
   parameter int unsigned MAX_RETRY       = MAX_RETRY_DEF,
   parameter int unsigned CNT_W           = CNT_W_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic       cam_pwdn,
   output logic       cam_rst_n,
   output logic       cfg_rst,
   input  logic       cfg_done,
   input  logic       cfg_error,
   output logic       busy,
   output logic       cam_ready,
   output logic       init_fail,
   output logic [3:0] retry_cnt
);

   localparam logic [CNT_W-1:0] PWDN_LOAD    = CNT_W'(PWDN_CYCLES - 1);
   localparam logic [CNT_W-1:0] RST_LOAD     = CNT_W'(RST_LOW_CYCLES - 1);
   localparam logic [CNT_W-1:0] WAIT_LOAD    = CNT_W'(RST_WAIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]       MAX_RETRY_W  = 4'(MAX_RETRY);

   logic [2:0]       state_q, state_d;
   logic [3:0]       retry_q, retry_d;
   pins_t            pins_q, pins_d;
   logic             tmr_load;
   logic [CNT_W-1:0] tmr_load_val;
   logic             tmr_expired;
   logic [CNT_W-1:0] tmr_count;
   logic             cfg_first;
   logic             attempt_failed;

   cam_init_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_load_val),
      .expired  (tmr_expired),
      .count    (tmr_count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         retry_q <= '0;
         pins_q  <= state_pins(ST_IDLE);
      end else begin
         state_q <= state_d;
         retry_q <= retry_d;
         pins_q  <= pins_d;
      end
   end

   // The timer still holds its load value only in the first CFG cycle, when done is stale.
   always_comb begin
      state_d        = state_q;
      retry_d        = retry_q;
      attempt_failed = 1'b0;
      cfg_first      = (tmr_count == TIMEOUT_LOAD);
      case (state_q)
         ST_IDLE, ST_READY, ST_FAIL: begin
            if (start) begin
               state_d = ST_PWDN;
               retry_d = '0;
            end
         end
         ST_PWDN: if (tmr_expired) state_d = ST_RST;
         ST_RST:  if (tmr_expired) state_d = ST_WAIT;
         ST_WAIT: if (tmr_expired) state_d = ST_CFG;
         ST_CFG: begin
            if (cfg_done && !cfg_first) begin
               if (cfg_error) begin
                  attempt_failed = 1'b1;
               end else begin
                  state_d = ST_READY;
               end
            end else if (tmr_expired) begin
               attempt_failed = 1'b1;
            end
            if (attempt_failed) begin
               if (retry_q < MAX_RETRY_W) begin
                  retry_d = retry_q + 4'd1;
                  state_d = ST_PWDN;
               end else begin
                  state_d = ST_FAIL;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so the registered pins track the state register.
   always_comb begin
      tmr_load     = (state_d != state_q);
      tmr_load_val = '0;
      case (state_d)
         ST_PWDN: tmr_load_val = PWDN_LOAD;
         ST_RST:  tmr_load_val = RST_LOAD;
         ST_WAIT: tmr_load_val = WAIT_LOAD;
         ST_CFG:  tmr_load_val = TIMEOUT_LOAD;
         default: tmr_load_val = '0;
      endcase
      pins_d = state_pins(state_d);
   end

   assign cam_pwdn  = pins_q.cam_pwdn;
   assign cam_rst_n = pins_q.cam_rst_n;
   assign cfg_rst   = pins_q.cfg_rst;
   assign busy      = pins_q.busy;
   assign cam_ready = pins_q.cam_ready;
   assign init_fail = pins_q.init_fail;
   assign retry_cnt = retry_q;

endmodule

// File: tb/tb_cam_init_ctrl.sv
// Directed bench for cam_init_ctrl with short timing parameters.
// Vector tables give per-cycle stimulus and the pin pattern expected in that cycle.
module tb_cam_init_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       cfg_done = 1'b0;
   logic       cfg_error = 1'b0;
   logic       cam_pwdn, cam_rst_n, cfg_rst, busy, cam_ready, init_fail;
   logic [3:0] retry_cnt;

   // Pin patterns: {cam_pwdn, cam_rst_n, cfg_rst, busy, cam_ready, init_fail}
   localparam bit [5:0] P_IDLE  = 6'b101000;
   localparam bit [5:0] P_PWDN  = 6'b101100;
   localparam bit [5:0] P_RST   = 6'b001100;
   localparam bit [5:0] P_WAIT  = 6'b011100;
   localparam bit [5:0] P_CFG   = 6'b010100;
   localparam bit [5:0] P_READY = 6'b010010;
   localparam bit [5:0] P_FAIL  = 6'b101001;

   typedef struct packed {
      logic [5:0] pins;
      logic [3:0] retry;
   } exp_t;

   typedef struct {
      int   cyc;
      logic start;
      logic cfg_done;
      logic cfg_error;
      exp_t exp;
   } vec_t;

   vec_t vecs[$];
   int   vecCount = 0;
   int   missCount = 0;
   int   cyc = 0;

   cam_init_ctrl #(
      .PWDN_CYCLES     (10),
      .RST_LOW_CYCLES  (5),
      .RST_WAIT_CYCLES (8),
      .TIMEOUT_CYCLES  (100),
      .MAX_RETRY       (2),
      .CNT_W           (32)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .cam_pwdn  (cam_pwdn),
      .cam_rst_n (cam_rst_n),
      .cfg_rst   (cfg_rst),
      .cfg_done  (cfg_done),
      .cfg_error (cfg_error),
      .busy      (busy),
      .cam_ready (cam_ready),
      .init_fail (init_fail),
      .retry_cnt (retry_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic doReset();
      rst_n     = 1'b0;
      start     = 1'b0;
      cfg_done  = 1'b0;
      cfg_error = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();
      cyc = 0;
   endtask

   task automatic addVec(input int c, input logic s, input logic d, input logic e,
                         input bit [5:0] p, input int r);
      vec_t v;
      v.cyc       = c;
      v.start     = s;
      v.cfg_done  = d;
      v.cfg_error = e;
      v.exp.pins  = p;
      v.exp.retry = 4'(r);
      vecs.push_back(v);
   endtask

   task automatic applyStimulus(input vec_t v);
      start     = v.start;
      cfg_done  = v.cfg_done;
      cfg_error = v.cfg_error;
   endtask

   task automatic checkOutput(input string name, input exp_t e);
      exp_t a;
      a.pins  = {cam_pwdn, cam_rst_n, cfg_rst, busy, cam_ready, init_fail};
      a.retry = retry_cnt;
      vecCount++;
      if (a !== e) begin
         missCount++;
         $display("[TB] FAIL %s: got pins=%b retry=%0d, expected pins=%b retry=%0d",
                  name, a.pins, a.retry, e.pins, e.retry);
      end
   endtask

   task automatic runVectors(input string tag);
      doReset();
      foreach (vecs[i]) begin
         while (cyc < vecs[i].cyc) step();
         applyStimulus(vecs[i]);
         checkOutput($sformatf("%s@c%0d", tag, vecs[i].cyc), vecs[i].exp);
      end
      vecs.delete();
   endtask

   initial begin
      exp_t e;

      // Clean bring-up; later done/error changes in READY are ignored.
      addVec(0,  1, 0, 0, P_IDLE,  0);
      addVec(1,  0, 0, 0, P_PWDN,  0);
      addVec(10, 0, 0, 0, P_PWDN,  0);
      addVec(11, 0, 0, 0, P_RST,   0);
      addVec(15, 0, 0, 0, P_RST,   0);
      addVec(16, 0, 0, 0, P_WAIT,  0);
      addVec(23, 0, 0, 0, P_WAIT,  0);
      addVec(24, 0, 0, 0, P_CFG,   0);
      addVec(43, 0, 0, 0, P_CFG,   0);
      addVec(44, 0, 1, 0, P_CFG,   0);
      addVec(45, 0, 1, 0, P_READY, 0);
      addVec(50, 0, 0, 1, P_READY, 0);
      addVec(55, 0, 1, 1, P_READY, 0);
      runVectors("clean");

      // Two error attempts, third clean.
      addVec(0,   1, 0, 0, P_IDLE,  0);
      addVec(1,   0, 0, 0, P_PWDN,  0);
      addVec(44,  0, 1, 1, P_CFG,   0);
      addVec(45,  0, 0, 0, P_PWDN,  1);
      addVec(55,  0, 0, 0, P_RST,   1);
      addVec(60,  0, 0, 0, P_WAIT,  1);
      addVec(68,  0, 0, 0, P_CFG,   1);
      addVec(88,  0, 1, 1, P_CFG,   1);
      addVec(89,  0, 0, 0, P_PWDN,  2);
      addVec(112, 0, 0, 0, P_CFG,   2);
      addVec(132, 0, 1, 0, P_CFG,   2);
      addVec(133, 0, 1, 0, P_READY, 2);
      runVectors("retry_err");

      // Done never arrives: three 100-cycle CFG windows, then FAIL; start from FAIL re-inits.
      addVec(0,   1, 0, 0, P_IDLE, 0);
      addVec(1,   0, 0, 0, P_PWDN, 0);
      addVec(24,  0, 0, 0, P_CFG,  0);
      addVec(123, 0, 0, 0, P_CFG,  0);
      addVec(124, 0, 0, 0, P_PWDN, 1);
      addVec(147, 0, 0, 0, P_CFG,  1);
      addVec(246, 0, 0, 0, P_CFG,  1);
      addVec(247, 0, 0, 0, P_PWDN, 2);
      addVec(270, 0, 0, 0, P_CFG,  2);
      addVec(369, 0, 0, 0, P_CFG,  2);
      addVec(370, 0, 0, 0, P_FAIL, 2);
      addVec(380, 0, 0, 0, P_FAIL, 2);
      addVec(381, 1, 0, 0, P_FAIL, 2);
      addVec(382, 0, 0, 0, P_PWDN, 0);
      runVectors("timeout");

      // start while busy is ignored; start in READY restarts from PWDN.
      addVec(0,  1, 0, 0, P_IDLE,  0);
      addVec(1,  0, 0, 0, P_PWDN,  0);
      addVec(5,  1, 0, 0, P_PWDN,  0);
      addVec(6,  0, 0, 0, P_PWDN,  0);
      addVec(11, 0, 0, 0, P_RST,   0);
      addVec(16, 0, 0, 0, P_WAIT,  0);
      addVec(24, 0, 0, 0, P_CFG,   0);
      addVec(30, 1, 0, 0, P_CFG,   0);
      addVec(31, 0, 0, 0, P_CFG,   0);
      addVec(44, 0, 1, 0, P_CFG,   0);
      addVec(45, 0, 1, 0, P_READY, 0);
      addVec(60, 1, 1, 0, P_READY, 0);
      addVec(61, 0, 0, 0, P_PWDN,  0);
      runVectors("start_busy");

      // Stale done across CFG entry is ignored; done on the timeout cycle wins.
      addVec(0,   1, 0, 0, P_IDLE,  0);
      addVec(1,   0, 0, 0, P_PWDN,  0);
      addVec(23,  0, 1, 0, P_WAIT,  0);
      addVec(24,  0, 1, 0, P_CFG,   0);
      addVec(25,  0, 0, 0, P_CFG,   0);
      addVec(122, 0, 0, 0, P_CFG,   0);
      addVec(123, 0, 1, 0, P_CFG,   0);
      addVec(124, 0, 0, 0, P_READY, 0);
      runVectors("stale_done");

      // Asynchronous reset in the middle of CFG.
      doReset();
      start = 1'b1;
      step();
      start = 1'b0;
      while (cyc < 30) step();
      e.pins = P_CFG;  e.retry = 4'd0;
      checkOutput("rst_pre", e);
      rst_n = 1'b0;
      #1;
      e.pins = P_IDLE; e.retry = 4'd0;
      checkOutput("rst_async", e);
      step();
      checkOutput("rst_held", e);
      rst_n = 1'b1;
      repeat (5) step();
      checkOutput("rst_idle", e);
      start = 1'b1;
      step();
      start = 1'b0;
      e.pins = P_PWDN; e.retry = 4'd0;
      checkOutput("rst_restart", e);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
